// File: rtl/dispatcher_pkg.sv
// Shared types for the dispatcher: kernel configuration, memory word types
// and the global and per-core scheduler state encodings.
package dispatcher_pkg;

  typedef logic [7:0] instruction_memory_address_t;
  typedef logic [7:0] data_memory_address_t;
  typedef logic [7:0] data_t;

  typedef struct packed {
    instruction_memory_address_t base_instructions_address;
    data_memory_address_t        base_data_address;
    logic [31:0]                 num_blocks;
  } kernel_config_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_RESET,
    C_RUN
  } core_state_t;

  localparam int BLOCK_ID_W = 8;

endpackage

// File: rtl/dispatcher.sv
// Block scheduler: latches the kernel block count on start, hands consecutive
// block IDs to idle cores and raises done once every block has completed.
module dispatcher
  import dispatcher_pkg::*;
#(
  parameter int NUM_CORES        = 2,
  parameter int WARPS_PER_CORE   = 4,
  parameter int THREADS_PER_WARP = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  kernel_config_t        kernel_config_reg,
  input  logic [NUM_CORES-1:0]  core_done,
  output logic [NUM_CORES-1:0]  core_start,
  output logic [NUM_CORES-1:0]  core_reset,
  output logic [BLOCK_ID_W-1:0] core_block_id [NUM_CORES],
  output logic                  done
);

  localparam int THREADS_PER_BLOCK = WARPS_PER_CORE * THREADS_PER_WARP;

  state_t      r_state;
  logic [31:0] r_num_blocks;
  logic [31:0] r_dispatched;
  logic [31:0] r_completed;

  logic [NUM_CORES-1:0]  w_core_idle;
  logic [NUM_CORES-1:0]  w_core_run;
  logic [NUM_CORES-1:0]  w_dispatch;
  logic [BLOCK_ID_W-1:0] w_next_id [NUM_CORES];
  logic [31:0]           w_disp_cnt;
  logic [31:0]           w_fin_cnt;
  logic [32:0]           w_completed_next;

  // Only num_blocks drives scheduling; the addresses belong to the cores.
  logic        w_unused_cfg;
  logic [15:0] w_unused_block_size;
  assign w_unused_cfg        = ^{kernel_config_reg.base_instructions_address,
                                 kernel_config_reg.base_data_address};
  assign w_unused_block_size = 16'(THREADS_PER_BLOCK);

  // Idle cores claim consecutive IDs in index order until blocks run out.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_disp_cnt = '0;
    w_fin_cnt  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_dispatch[i] = 1'b0;
      w_next_id[i]  = '0;
      if (r_state == S_RUNNING && w_core_idle[i] &&
          ({1'b0, r_dispatched} + {1'b0, w_disp_cnt}) < {1'b0, r_num_blocks}) begin
        w_dispatch[i] = 1'b1;
        w_next_id[i]  = BLOCK_ID_W'(r_dispatched + w_disp_cnt);
        w_disp_cnt    = w_disp_cnt + 32'd1;
      end
      if (w_core_run[i] && core_done[i]) begin
        w_fin_cnt = w_fin_cnt + 32'd1;
      end
    end
  end

  assign w_completed_next = {1'b0, r_completed} + {1'b0, w_fin_cnt};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every other register.
  // NOTE: reset clears only control state and counters; there is no memory here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_num_blocks <= '0;
      r_dispatched <= '0;
      r_completed  <= '0;
      done         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_blocks <= kernel_config_reg.num_blocks;
            r_dispatched <= '0;
            r_completed  <= '0;
            if (kernel_config_reg.num_blocks == 32'd0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= S_RUNNING;
            end
          end
        end
        S_RUNNING: begin
          r_dispatched <= r_dispatched + w_disp_cnt;
          r_completed  <= w_completed_next[31:0];
          if (w_completed_next == {1'b0, r_num_blocks}) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE:  done <= 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    core_state_t           r_core_state;
    logic                  r_start;
    logic                  r_reset;
    logic [BLOCK_ID_W-1:0] r_block_id;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_core_state <= C_IDLE;
        r_start      <= 1'b0;
        r_reset      <= 1'b0;
        r_block_id   <= '0;
      end else begin
        case (r_core_state)
          C_IDLE: begin
            r_start <= 1'b0;
            r_reset <= 1'b1;
            if (w_dispatch[i]) begin
              r_core_state <= C_RESET;
              r_reset      <= 1'b0;
              r_block_id   <= w_next_id[i];
            end
          end
          C_RESET: begin
            r_core_state <= C_RUN;
            r_reset      <= 1'b1;
            r_start      <= 1'b1;
          end
          C_RUN: begin
            if (core_done[i]) begin
              r_core_state <= C_IDLE;
              r_start      <= 1'b0;
            end
          end
          default: r_core_state <= C_IDLE;
        endcase
      end
    end

    assign w_core_idle[i]   = (r_core_state == C_IDLE);
    assign w_core_run[i]    = (r_core_state == C_RUN);
    assign core_start[i]    = r_start;
    assign core_reset[i]    = r_reset;
    assign core_block_id[i] = r_block_id;
  end

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for the dispatcher: two cores, hand-computed expectations
// checked one time unit after each rising edge.
module tb_dispatcher;
  import dispatcher_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  kernel_config_t kernel_config_reg;
  logic [1:0]     core_done;
  logic [1:0]     core_start;
  logic [1:0]     core_reset;
  logic [7:0]     core_block_id [2];
  logic           done;

  int n_cmp = 0;
  int n_err = 0;

  dispatcher #(.NUM_CORES(2), .WARPS_PER_CORE(4), .THREADS_PER_WARP(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .kernel_config_reg(kernel_config_reg),
    .core_done        (core_done),
    .core_start       (core_start),
    .core_reset       (core_reset),
    .core_block_id    (core_block_id),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    core_done = 2'b00;
    kernel_config_reg = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic launch(input logic [31:0] n);
    kernel_config_reg.num_blocks = n;
    kernel_config_reg.base_instructions_address = 8'h10;
    kernel_config_reg.base_data_address = 8'h20;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    core_done = 2'b00;
    kernel_config_reg = '0;
    tick();
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
    n_cmp++; if (core_start !== 2'b00) begin n_err++; $display("FAIL rst_start got=%b exp=00", core_start); end
    n_cmp++; if (core_reset !== 2'b00) begin n_err++; $display("FAIL rst_core_reset got=%b exp=00", core_reset); end
    n_cmp++; if (core_block_id[0] !== 8'd0 || core_block_id[1] !== 8'd0) begin n_err++;
      $display("FAIL rst_ids got=%0d/%0d exp=0/0", core_block_id[0], core_block_id[1]); end
    reset = 1'b1;
    tick();
    n_cmp++; if (core_reset !== 2'b11) begin n_err++; $display("FAIL rst_release got=%b exp=11", core_reset); end
  endtask

  task automatic test_two_blocks();
    do_reset();
    launch(32'd2);
    n_cmp++; if (core_reset !== 2'b11 || core_start !== 2'b00) begin n_err++;
      $display("FAIL tb2_edgeN reset=%b start=%b exp=11/00", core_reset, core_start); end
    tick();
    n_cmp++; if (core_reset !== 2'b00 || core_start !== 2'b00) begin n_err++;
      $display("FAIL tb2_edgeN1 reset=%b start=%b exp=00/00", core_reset, core_start); end
    n_cmp++; if (core_block_id[0] !== 8'd0 || core_block_id[1] !== 8'd1) begin n_err++;
      $display("FAIL tb2_ids got=%0d/%0d exp=0/1", core_block_id[0], core_block_id[1]); end
    tick();
    n_cmp++; if (core_reset !== 2'b11 || core_start !== 2'b11) begin n_err++;
      $display("FAIL tb2_edgeN2 reset=%b start=%b exp=11/11", core_reset, core_start); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL tb2_early_done got=%b exp=0", done); end
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    n_cmp++; if (done !== 1'b1 || core_start !== 2'b00) begin n_err++;
      $display("FAIL tb2_done done=%b start=%b exp=1/00", done, core_start); end
    tick();
    n_cmp++; if (done !== 1'b1 || core_reset !== 2'b11) begin n_err++;
      $display("FAIL tb2_hold done=%b reset=%b exp=1/11", done, core_reset); end
  endtask

  task automatic test_five_blocks();
    do_reset();
    launch(32'd5);
    tick();
    tick();
    n_cmp++; if (core_start !== 2'b11 || core_block_id[0] !== 8'd0 || core_block_id[1] !== 8'd1) begin n_err++;
      $display("FAIL tb5_first start=%b ids=%0d/%0d exp=11 0/1", core_start, core_block_id[0], core_block_id[1]); end
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    n_cmp++; if (core_start !== 2'b10) begin n_err++; $display("FAIL tb5_c0_fall got=%b exp=10", core_start); end
    tick();
    n_cmp++; if (core_reset !== 2'b10 || core_block_id[0] !== 8'd2) begin n_err++;
      $display("FAIL tb5_c0_id2 reset=%b id=%0d exp=10/2", core_reset, core_block_id[0]); end
    tick();
    n_cmp++; if (core_start !== 2'b11 || core_reset !== 2'b11) begin n_err++;
      $display("FAIL tb5_c0_run start=%b reset=%b exp=11/11", core_start, core_reset); end
    core_done = 2'b10;
    tick();
    core_done = 2'b00;
    tick();
    n_cmp++; if (core_reset !== 2'b01 || core_block_id[1] !== 8'd3) begin n_err++;
      $display("FAIL tb5_c1_id3 reset=%b id=%0d exp=01/3", core_reset, core_block_id[1]); end
    tick();
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    tick();
    n_cmp++; if (core_reset !== 2'b10 || core_block_id[0] !== 8'd4) begin n_err++;
      $display("FAIL tb5_c0_id4 reset=%b id=%0d exp=10/4", core_reset, core_block_id[0]); end
    tick();
    core_done = 2'b10;
    tick();
    core_done = 2'b00;
    tick();
    n_cmp++; if (core_reset !== 2'b11 || core_start !== 2'b01 || done !== 1'b0) begin n_err++;
      $display("FAIL tb5_no_sixth reset=%b start=%b done=%b exp=11/01/0", core_reset, core_start, done); end
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL tb5_done got=%b exp=1", done); end
  endtask

  task automatic test_zero_blocks();
    do_reset();
    launch(32'd0);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done got=%b exp=1", done); end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    n_cmp++; if (done !== 1'b1 || core_reset !== 2'b11 || core_start !== 2'b00) begin n_err++;
      $display("FAIL zero_quiet done=%b reset=%b start=%b exp=1/11/00", done, core_reset, core_start); end
  endtask

  task automatic test_simultaneous_finish();
    do_reset();
    launch(32'd3);
    tick();
    tick();
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    n_cmp++; if (done !== 1'b0 || core_start !== 2'b00) begin n_err++;
      $display("FAIL sim_fin done=%b start=%b exp=0/00", done, core_start); end
    tick();
    n_cmp++; if (core_reset !== 2'b10 || core_block_id[0] !== 8'd2) begin n_err++;
      $display("FAIL sim_redisp reset=%b id0=%0d exp=10/2", core_reset, core_block_id[0]); end
    tick();
    n_cmp++; if (core_start !== 2'b01) begin n_err++; $display("FAIL sim_c1_idle start=%b exp=01", core_start); end
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL sim_done got=%b exp=1", done); end
  endtask

  task automatic test_done_ignored();
    do_reset();
    kernel_config_reg.num_blocks = 32'd2;
    start = 1'b1;
    core_done = 2'b11;
    tick();
    start = 1'b0;
    tick();
    tick();
    core_done = 2'b00;
    n_cmp++; if (done !== 1'b0 || core_start !== 2'b11) begin n_err++;
      $display("FAIL ign_idle_reset done=%b start=%b exp=0/11", done, core_start); end
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ign_partial done=%b exp=0", done); end
    core_done = 2'b10;
    tick();
    core_done = 2'b00;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ign_final done=%b exp=1", done); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    launch(32'd5);
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b0 || core_start !== 2'b00 || core_reset !== 2'b00) begin n_err++;
      $display("FAIL mid_rst done=%b start=%b reset=%b exp=0/00/00", done, core_start, core_reset); end
    reset = 1'b1;
    tick();
    launch(32'd3);
    kernel_config_reg.num_blocks = 32'd1;
    tick();
    n_cmp++; if (core_block_id[0] !== 8'd0 || core_block_id[1] !== 8'd1) begin n_err++;
      $display("FAIL mid_restart ids=%0d/%0d exp=0/1", core_block_id[0], core_block_id[1]); end
    tick();
    core_done = 2'b11;
    tick();
    core_done = 2'b00;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL cfg_latch_done got=%b exp=0", done); end
    tick();
    n_cmp++; if (core_reset !== 2'b10 || core_block_id[0] !== 8'd2) begin n_err++;
      $display("FAIL cfg_latch_third reset=%b id0=%0d exp=10/2", core_reset, core_block_id[0]); end
    tick();
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL cfg_latch_final done=%b exp=1", done); end
  endtask

  task automatic test_id_wrap();
    logic [31:0] id0;
    logic [31:0] id1;
    do_reset();
    launch(32'd258);
    tick();
    tick();
    for (int k = 0; k < 129; k++) begin
      id0 = 32'(2 * k);
      id1 = 32'(2 * k + 1);
      n_cmp++; if (core_block_id[0] !== id0[7:0] || core_block_id[1] !== id1[7:0]) begin n_err++;
        $display("FAIL wrap_ids round=%0d got=%0d/%0d exp=%0d/%0d", k,
                 core_block_id[0], core_block_id[1], id0[7:0], id1[7:0]); end
      core_done = 2'b11;
      tick();
      core_done = 2'b00;
      if (k < 128) begin
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL wrap_early_done round=%0d got=%b exp=0", k, done); end
        tick();
        tick();
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done got=%b exp=1", done); end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    core_done = 2'b00;
    kernel_config_reg = '0;
    test_reset();
    test_two_blocks();
    test_five_blocks();
    test_zero_blocks();
    test_simultaneous_finish();
    test_done_ignored();
    test_reset_mid_run();
    test_id_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
